// File: rtl/poly_pkg.sv
// Shared types for the polyphonic voice sequencer: FSM state encoding and
// the voice-index width helper used by poly_seq_ctrl and its delay line.
package poly_pkg;

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } poly_state_t;

   // Voice index must be able to represent NUM_OSC itself (end-of-sweep marker).
   function automatic int osc_width(input int num_osc);
      return $clog2(num_osc + 1);
   endfunction

endpackage

// File: rtl/poly_acc_pipe.sv
// Fixed-latency {valid, tag} shift line carrying each divider launch to its
// accumulate strobe; freezes when en is low, reports empty when nothing is in flight.
module poly_acc_pipe #(
   parameter int DEPTH = 24,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag,
   output logic             empty
);

   logic [DEPTH-1:0] valid_r;
   logic [TAG_W-1:0] tag_r [DEPTH];

   // Shift one stage per enabled cycle; idle slots carry a zero tag.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         valid_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_r[i] <= '0;
         end
      end else if (en) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            valid_r[i] <= valid_r[i-1];
            tag_r[i]   <= tag_r[i-1];
         end
         valid_r[0] <= in_valid;
         tag_r[0]   <= in_valid ? in_tag : '0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign out_valid = valid_r[DEPTH-1];
   assign out_tag   = tag_r[DEPTH-1];
   assign empty     = ~(|valid_r);

endmodule

// File: rtl/poly_seq_ctrl.sv
// Per-sample voice sweep sequencer feeding the shared divider and accumulator.
// Define POLY_SEQ_MASK_EN to honour voice_mask; otherwise every voice is swept.
module poly_seq_ctrl
   import poly_pkg::*;
#(
   parameter int NUM_OSC   = 13,
   parameter int ACC_DELAY = 24,
   parameter int OSC_W     = osc_width(NUM_OSC)
) (
   input  logic               MHz10,
   input  logic               nrst,
   input  logic               en,
   input  logic [NUM_OSC-1:0] voice_mask,
   input  logic               ready,
   input  logic               samp_enable,
   output logic               start,
   output logic [OSC_W-1:0]   osc_num,
   output logic               acc,
   output logic [OSC_W-1:0]   acc_osc,
   output logic               store_samp,
   output logic               clr,
   output logic               overrun
);

   poly_state_t      state_r;
   logic [OSC_W-1:0] osc_num_r;
   logic             sweep_done_s;
   logic             voice_on_s;
   logic             start_s;
   logic             pipe_valid_s;
   logic [OSC_W-1:0] pipe_tag_s;
   logic             pipe_empty_s;

   assign sweep_done_s = (osc_num_r == OSC_W'(NUM_OSC));

`ifdef POLY_SEQ_MASK_EN
   // Voice activity from the mask; the end-of-sweep index is never active.
   always_comb begin
      voice_on_s = 1'b0;
      if (sweep_done_s) begin
         voice_on_s = 1'b0;
      end else begin
         voice_on_s = voice_mask[osc_num_r];
      end
   end
`else
   logic mask_unused_s;
   assign mask_unused_s = ^voice_mask;

   // Legacy full sweep: every voice is treated as active.
   always_comb begin
      voice_on_s = 1'b1;
   end
`endif

   // Launch the divider for the current voice when it is active and ready.
   always_comb begin
      start_s = 1'b0;
      if (nrst && en && (state_r == SCAN) && !sweep_done_s && voice_on_s && ready) begin
         start_s = 1'b1;
      end else begin
         start_s = 1'b0;
      end
   end

   // Sweep FSM: every transition and index update waits for en.
   always_ff @(posedge MHz10 or negedge nrst) begin
      if (!nrst) begin
         state_r   <= SCAN;
         osc_num_r <= '0;
      end else if (en) begin
         case (state_r)
            SCAN: begin
               if (sweep_done_s) begin
                  state_r <= DRAIN;
               end else if (!voice_on_s) begin
                  osc_num_r <= osc_num_r + OSC_W'(1);
               end else if (ready) begin
                  state_r <= ISSUE;
               end else begin
                  state_r <= SCAN;
               end
            end
            ISSUE: begin
               osc_num_r <= osc_num_r + OSC_W'(1);
               state_r   <= SCAN;
            end
            DRAIN: begin
               if (pipe_empty_s) begin
                  state_r <= HOLD;
               end else begin
                  state_r <= DRAIN;
               end
            end
            HOLD: begin
               if (samp_enable) begin
                  osc_num_r <= '0;
                  state_r   <= SCAN;
               end else begin
                  state_r <= HOLD;
               end
            end
            default: begin
               state_r   <= SCAN;
               osc_num_r <= '0;
            end
         endcase
      end else begin
         state_r <= state_r;
      end
   end

   poly_acc_pipe #(
      .DEPTH (ACC_DELAY),
      .TAG_W (OSC_W)
   ) u_acc_pipe (
      .clk       (MHz10),
      .nrst      (nrst),
      .en        (en),
      .in_valid  (start_s),
      .in_tag    (osc_num_r),
      .out_valid (pipe_valid_s),
      .out_tag   (pipe_tag_s),
      .empty     (pipe_empty_s)
   );

   // Strobes are gated by en (and reset) so a frozen sequencer emits nothing.
   always_comb begin
      store_samp = 1'b0;
      overrun    = 1'b0;
      acc        = 1'b0;
      if (nrst && en) begin
         store_samp = samp_enable && (state_r == HOLD);
         overrun    = samp_enable && (state_r != HOLD);
         acc        = pipe_valid_s;
      end else begin
         store_samp = 1'b0;
         overrun    = 1'b0;
         acc        = 1'b0;
      end
   end

   assign start   = start_s;
   assign clr     = store_samp;
   assign osc_num = osc_num_r;
   assign acc_osc = pipe_tag_s;

endmodule

// File: tb/tb_poly_seq_ctrl.sv
// Directed bench for poly_seq_ctrl: logs start/acc events per cycle and
// compares them against hand-derived sweep order and latency.
module tb_poly_seq_ctrl;

   logic        MHz10 = 1'b0;
   logic        nrst;
   logic        en;
   logic [12:0] voice_mask;
   logic        ready;
   logic        samp_enable;
   logic        start;
   logic [3:0]  osc_num;
   logic        acc;
   logic [3:0]  acc_osc;
   logic        store_samp;
   logic        clr;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int st_cyc[$];
   int st_osc[$];
   int ac_cyc[$];
   int ac_tag[$];
   int exp_q[$];
   int store_cnt = 0;
   int ovr_cnt   = 0;
   int gap_at    = -1;
   int gap_len   = 0;
   int s_cyc;

   poly_seq_ctrl dut (
      .MHz10       (MHz10),
      .nrst        (nrst),
      .en          (en),
      .voice_mask  (voice_mask),
      .ready       (ready),
      .samp_enable (samp_enable),
      .start       (start),
      .osc_num     (osc_num),
      .acc         (acc),
      .acc_osc     (acc_osc),
      .store_samp  (store_samp),
      .clr         (clr),
      .overrun     (overrun)
   );

   always #50 MHz10 = ~MHz10;

   always @(posedge MHz10) cyc <= cyc + 1;

   // Event log sampled mid-cycle, away from the active edge.
   always @(negedge MHz10) begin
      if (nrst) begin
         if (start) begin
            st_cyc.push_back(cyc);
            st_osc.push_back(int'(osc_num));
         end
         if (acc) begin
            ac_cyc.push_back(cyc);
            ac_tag.push_back(int'(acc_osc));
         end
         if (store_samp) store_cnt++;
         if (overrun) ovr_cnt++;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge MHz10);
      end
      #1;
   endtask

   task automatic clear_log();
      st_cyc.delete();
      st_osc.delete();
      ac_cyc.delete();
      ac_tag.delete();
      store_cnt = 0;
      ovr_cnt   = 0;
   endtask

   task automatic build_exp(input logic [12:0] m);
      exp_q.delete();
      for (int i = 0; i < 13; i++) begin
`ifdef POLY_SEQ_MASK_EN
         if (m[i])
`endif
            exp_q.push_back(i);
      end
   endtask

   // Compare the logged sweep against exp_q; acc lags start by 24 plus any en gap.
   task automatic verify_sweep(input string nm);
      int dly;
      check_val({nm, "_nstart"}, st_cyc.size(), exp_q.size());
      check_val({nm, "_nacc"}, ac_cyc.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < st_osc.size()) check_val({nm, "_start_osc"}, st_osc[i], exp_q[i]);
         if (i < ac_tag.size()) check_val({nm, "_acc_osc"}, ac_tag[i], exp_q[i]);
         if (i < ac_cyc.size() && i < st_cyc.size()) begin
            dly = 24 + ((st_cyc[i] < gap_at) ? gap_len : 0);
            check_val({nm, "_acc_lat"}, ac_cyc[i] - st_cyc[i], dly);
         end
         if (i > 0 && i < st_cyc.size())
            check_val({nm, "_gap_ge2"}, 32'(st_cyc[i] - st_cyc[i-1] >= 2), 32'd1);
      end
   endtask

   // From HOLD: one samp_enable pulse stores, then the new sweep runs to completion.
   task automatic store_and_sweep(input string nm, input logic [12:0] m);
      voice_mask = m;
      tick(1);
      samp_enable = 1'b1;
      clear_log();
      @(negedge MHz10);
      check_val({nm, "_store"}, store_samp, 1'b1);
      check_val({nm, "_clr"}, clr, 1'b1);
      tick(1);
      samp_enable = 1'b0;
      @(negedge MHz10);
      check_val({nm, "_osc0"}, osc_num, 4'd0);
      tick(60);
      build_exp(m);
      verify_sweep(nm);
      check_val({nm, "_hold_osc"}, osc_num, 4'd13);
   endtask

   initial begin
      nrst        = 1'b0;
      en          = 1'b1;
      voice_mask  = 13'h1FFF;
      ready       = 1'b1;
      samp_enable = 1'b0;

      // Reset state
      @(negedge MHz10);
      check_val("rst_start", start, 1'b0);
      check_val("rst_acc", acc, 1'b0);
      check_val("rst_osc", osc_num, 4'd0);
      check_val("rst_acc_osc", acc_osc, 4'd0);
      check_val("rst_store", store_samp, 1'b0);
      check_val("rst_overrun", overrun, 1'b0);
      tick(2);

      // Full sweep, all voices, ready high
      clear_log();
      nrst = 1'b1;
      tick(60);
      build_exp(13'h1FFF);
      verify_sweep("t1");
      for (int i = 1; i < st_cyc.size(); i++) begin
         check_val("t1_gap2", st_cyc[i] - st_cyc[i-1], 2);
      end
      check_val("t1_hold_osc", osc_num, 4'd13);
      check_val("t1_no_store", store_cnt, 0);

      // Store, then overruns in SCAN and DRAIN
      tick(1);
      samp_enable = 1'b1;
      s_cyc = cyc;
      clear_log();
      @(negedge MHz10);
      check_val("t2_store", store_samp, 1'b1);
      check_val("t2_clr", clr, 1'b1);
      check_val("t2_no_ovr", overrun, 1'b0);
      tick(1);
      samp_enable = 1'b0;
      clear_log();
      @(negedge MHz10);
      check_val("t2_osc0", osc_num, 4'd0);
      check_val("t2_start", start, 1'b1);
      tick(4);
      samp_enable = 1'b1;
      @(negedge MHz10);
      check_val("t2_ovr_scan", overrun, 1'b1);
      check_val("t2_ovr_scan_nostore", store_samp, 1'b0);
      tick(1);
      samp_enable = 1'b0;
      tick(s_cyc + 35 - cyc);
      samp_enable = 1'b1;
      @(negedge MHz10);
      check_val("t2_ovr_drain", overrun, 1'b1);
      check_val("t2_ovr_drain_nostore", store_samp, 1'b0);
      tick(1);
      samp_enable = 1'b0;
      tick(s_cyc + 65 - cyc);
      build_exp(13'h1FFF);
      verify_sweep("t2");
      check_val("t2_ovr_cnt", ovr_cnt, 2);
      check_val("t2_store_cnt", store_cnt, 0);
      check_val("t2_hold_osc", osc_num, 4'd13);

      // Voice masks (ignored unless POLY_SEQ_MASK_EN)
      store_and_sweep("m5", 13'h0005);
      store_and_sweep("m0", 13'h0000);
      store_and_sweep("mall", 13'h1FFF);

      // ready low for 5 cycles, then en low for 3 cycles mid-pipeline
      tick(1);
      samp_enable = 1'b1;
      s_cyc = cyc;
      clear_log();
      tick(1);
      samp_enable = 1'b0;
      ready = 1'b0;
      @(negedge MHz10);
      check_val("t4_wait_ready", start, 1'b0);
      tick(5);
      ready = 1'b1;
      tick(7);
      en = 1'b0;
      samp_enable = 1'b1;
      gap_at  = cyc;
      gap_len = 3;
      @(negedge MHz10);
      check_val("t4_en_ovr", overrun, 1'b0);
      check_val("t4_en_start", start, 1'b0);
      check_val("t4_en_acc", acc, 1'b0);
      tick(1);
      samp_enable = 1'b0;
      tick(2);
      en = 1'b1;
      tick(60);
      build_exp(13'h1FFF);
      verify_sweep("t4");
      if (st_cyc.size() > 0) check_val("t4_first_start", st_cyc[0] - s_cyc, 6);
      gap_at  = -1;
      gap_len = 0;

      // Reset with 4 entries in flight
      tick(1);
      samp_enable = 1'b1;
      tick(1);
      samp_enable = 1'b0;
      tick(7);
      nrst = 1'b0;
      @(negedge MHz10);
      check_val("t5_start", start, 1'b0);
      check_val("t5_acc", acc, 1'b0);
      check_val("t5_osc", osc_num, 4'd0);
      check_val("t5_acc_osc", acc_osc, 4'd0);
      check_val("t5_store", store_samp, 1'b0);
      check_val("t5_clr", clr, 1'b0);
      check_val("t5_overrun", overrun, 1'b0);
      tick(2);
      clear_log();
      nrst = 1'b1;
      tick(60);
      build_exp(13'h1FFF);
      verify_sweep("t5");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/poly_seq_ctrl.md
# poly_seq_ctrl

Parametrised sequencer for the polyphonic synth core. It sweeps oscillator voices 0..NUM_OSC-1 once per audio sample, handshakes each voice into the shared divider, and emits a delayed accumulate strobe tagged with the voice index. It drains in-flight results before committing the sample on `samp_enable`, and flags sample-rate overruns. It sits between the sample-rate generator and the divider/accumulator datapath.

## Interface
- `NUM_OSC`, 13, number of voices swept per sample (≥1).
- `ACC_DELAY`, 24, cycles from `start` to the matching `acc` (divider + datapath latency, ≥1).
- `OSC_W`, `$clog2(NUM_OSC+1)`, voice-index width; derived, must hold the value NUM_OSC.
- `MHz10`  in  1  system clock, rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  global enable; low freezes all state.
- `voice_mask`  in  NUM_OSC  per-voice active bits (bit i = voice i).
- `ready`  in  1  divider can accept a new operation.
- `samp_enable`  in  1  one-cycle sample-rate tick.
- `start`  out  1  launch divider for voice `osc_num`.
- `osc_num`  out  OSC_W  voice currently being scanned.
- `acc`  out  1  accumulate strobe, ACC_DELAY cycles after `start`.
- `acc_osc`  out  OSC_W  voice index belonging to `acc`.
- `store_samp`  out  1  latch the accumulated sample.
- `clr`  out  1  clear the accumulator (coincident with `store_samp`).
- `overrun`  out  1  `samp_enable` arrived before the sweep finished.

## Operation
- States: SCAN, ISSUE, DRAIN, HOLD. Reset state: SCAN, `osc_num`=0, pipeline empty.
- SCAN:
  - `osc_num`==NUM_OSC → DRAIN.
  - Voice masked → `osc_num`+1, stay in SCAN.
  - Else, if `ready` → `start`=1, push {valid=1, tag=`osc_num`} into the delay line, go to ISSUE.
  - Else → wait in SCAN.
- ISSUE: `osc_num`+1 → SCAN. Each active voice costs at least 2 cycles; each masked voice costs 1.
- DRAIN: stay until no valid entry remains in the delay line → HOLD.
- HOLD: on `samp_enable` → `store_samp`=`clr`=1 for that cycle, `osc_num`←0, go to SCAN.
- `samp_enable` while `en` is high and the state is not HOLD → `overrun`=1 in that cycle. The sample is not stored and the sweep continues unaffected.
- `en` low:
  - State, `osc_num` and the delay line hold.
  - `start`, `store_samp`, `clr`, `overrun` and `acc` are forced to 0.
  - `acc_osc` holds.
  - In-flight entries resume when `en` returns.
- Delay line: ACC_DELAY stages of {valid, tag}. It shifts every enabled cycle and inserts valid=0 when there is no `start`.
- All-masked voice set: the sweep goes SCAN→DRAIN→HOLD with no `start` issued. The next `samp_enable` still stores (storing zero).

## Timing
- `start`, `store_samp`, `clr`, `overrun`: combinational from state and inputs, same cycle.
- `start` in cycle t → `acc`=1 and `acc_osc`=tag in cycle t+ACC_DELAY (registered tail).
- Back-to-back voices: `start` pulses at least 2 cycles apart.
- HOLD is entered only when the pipeline is empty, so no `acc` follows a `store_samp` from the previous sweep.
- Reset values: all outputs 0. Reset mid-sweep clears the delay line immediately, with no stray `acc`.

## Configuration
- `POLY_SEQ_MASK_EN` defined: `voice_mask` is honoured as described.
- Undefined: `voice_mask` is ignored and every voice is treated as active, which is the legacy full-sweep behaviour. The port remains present.

## Structure
- Package `poly_pkg`: state typedef (SCAN/ISSUE/DRAIN/HOLD) and encodings, plus a shared helper for OSC_W.
- One sub-module, `poly_acc_pipe`: parametrised {valid, tag} shift line with enable and an `empty` output (OR of the valid bits).

## Test plan
- Reset, NUM_OSC=13, ACC_DELAY=24, all voices active, `ready`=1 → 13 `start` pulses 2 cycles apart, then 13 `acc` pulses with `acc_osc`=0..12, each 24 cycles after its `start`. HOLD is entered after the last `acc`.
- HOLD, then `samp_enable` → `store_samp`=`clr`=1 for one cycle, `osc_num`=0, and the next sweep begins.
- `POLY_SEQ_MASK_EN` set, `voice_mask`=13'h0005 → `start` only for voices 0 and 2; `acc_osc` sequence is 0, 2. All-zero mask → no `start`, HOLD reached.
- `samp_enable` during SCAN or DRAIN → `overrun`=1 for one cycle, no `store_samp`, sweep unchanged.
- `ready` held low for 5 cycles in SCAN, and `en` dropped for 3 cycles mid-pipeline → `start` waits for `ready`; `acc` timing shifts by exactly 3 cycles.
- `nrst` asserted with 4 entries in flight → all outputs 0, and no `acc` after release until new `start` pulses.
